// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory bus decoder and its address matcher.
// Also holds the base/mask memory map of the current stepper board.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

   localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;
   localparam int          ERR_COUNT_WIDTH    = 8;

   localparam int          STEPPER_SLAVES = 9;
   localparam logic [31:0] ROM_BASE = 32'h0000_0000;
   localparam logic [31:0] ROM_MASK = 32'hFFFF_F000;
   localparam logic [31:0] RAM_BASE = 32'h0000_1000;
   localparam logic [31:0] RAM_MASK = 32'hFFFF_F000;
   localparam logic [31:0] IO_BASE  = 32'h1000_0000;
   localparam logic [31:0] IO_MASK  = 32'hFFFF_FFFC;

   // Slot 0 is ROM, slot 1 is RAM, slots 2..8 are IO registers k = 0..6.
   localparam logic [STEPPER_SLAVES*32-1:0] STEPPER_BASE = {
      IO_BASE + 32'h18, IO_BASE + 32'h14, IO_BASE + 32'h10, IO_BASE + 32'h0C,
      IO_BASE + 32'h08, IO_BASE + 32'h04, IO_BASE, RAM_BASE, ROM_BASE};
   localparam logic [STEPPER_SLAVES*32-1:0] STEPPER_MASK = {
      {7{IO_MASK}}, RAM_MASK, ROM_MASK};

endpackage

// File: rtl/mem_bus_addr_match.sv
// Priority mask/base region matcher: one-hot select of the lowest matching region.
// Purely combinational so it can be shared with other bus masters.
module mem_bus_addr_match #(
   parameter int                             SLAVES     = 9,
   parameter int                             ADDR_WIDTH = 32,
   parameter logic [SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE = '0,
   parameter logic [SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [SLAVES-1:0]     sel,
   output logic                  hit
);

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < SLAVES; i++) begin
         if (!hit && ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                      == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_decoder.sv
// picorv32 native-port decoder: registered one-hot selects, read-data mux,
// per-access timeout and error response for unmapped or stalled accesses.
//
// state   | meaning
// IDLE    | waiting for mem_valid_in; decode and launch or reject
// WAIT    | slave selected, counting cycles until its ready or timeout
// RESP    | r_mem_ready_out high for this one cycle
module mem_bus_decoder
   import mem_bus_pkg::*;
#(
   parameter int                           SLAVES         = 9,
   parameter int                           ADDR_WIDTH     = 32,
   parameter int                           DATA_WIDTH     = 32,
   parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     = '0,
   parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     = '0,
   parameter int                           TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0]        ERROR_DATA     = DATA_WIDTH'(ERROR_DATA_DEFAULT)
) (
   input  logic                         clk_in,
   input  logic                         reset_n_in,
   input  logic                         mem_valid_in,
   input  logic [ADDR_WIDTH-1:0]        mem_addr_in,
   input  logic [3:0]                   mem_wstrb_in,
   output logic                         r_mem_ready_out,
   output logic [DATA_WIDTH-1:0]        r_mem_rdata_out,
   output logic [SLAVES-1:0]            r_sel_out,
   output logic                         r_write_out,
   input  logic [SLAVES-1:0]            slave_ready_in,
   input  logic [SLAVES*DATA_WIDTH-1:0] slave_rdata_in,
   output logic                         r_err_out,
   output logic [ERR_COUNT_WIDTH-1:0]   r_err_count_out
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   bus_state_t             state;
   logic [15:0]            wait_cnt;
   logic [SLAVES-1:0]      match_sel;
   logic                   match_hit;
   logic                   sel_ready;
   logic [DATA_WIDTH-1:0]  sel_rdata;

   mem_bus_addr_match #(
      .SLAVES     (SLAVES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_addr_match (
      .addr (mem_addr_in),
      .sel  (match_sel),
      .hit  (match_hit)
   );

   // Select is one-hot, so an AND-OR mux is enough; unselected readies drop out.
   assign sel_ready = |(slave_ready_in & r_sel_out);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (r_sel_out[i]) sel_rdata = sel_rdata | slave_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         r_sel_out       <= '0;
         r_write_out     <= 1'b0;
         r_mem_ready_out <= 1'b0;
         r_mem_rdata_out <= '0;
         r_err_out       <= 1'b0;
         r_err_count_out <= '0;
      end else begin
         r_mem_ready_out <= 1'b0;
         r_err_out       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_valid_in) begin
                  if (match_hit) begin
                     r_sel_out   <= match_sel;
                     r_write_out <= |mem_wstrb_in;
                     wait_cnt    <= '0;
                     state       <= ST_WAIT;
                  end else begin
                     r_mem_rdata_out <= ERROR_DATA;
                     r_mem_ready_out <= 1'b1;
                     r_err_out       <= 1'b1;
                     if (r_err_count_out != '1) r_err_count_out <= r_err_count_out + 1'b1;
                     state           <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               // A dropped valid is a CPU protocol violation: abandon quietly.
               if (!mem_valid_in) begin
                  r_sel_out   <= '0;
                  r_write_out <= 1'b0;
                  state       <= ST_IDLE;
               end else if (sel_ready) begin
                  r_mem_rdata_out <= sel_rdata;
                  r_sel_out       <= '0;
                  r_write_out     <= 1'b0;
                  r_mem_ready_out <= 1'b1;
                  state           <= ST_RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  r_mem_rdata_out <= ERROR_DATA;
                  r_sel_out       <= '0;
                  r_write_out     <= 1'b0;
                  r_mem_ready_out <= 1'b1;
                  r_err_out       <= 1'b1;
                  if (r_err_count_out != '1) r_err_count_out <= r_err_count_out + 1'b1;
                  state           <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed-vector bench for mem_bus_decoder on the stepper map with a 4-cycle timeout,
// plus a two-region instance with overlapping regions.
module tb_mem_bus_decoder;
   import mem_bus_pkg::*;

   logic          clk_25mhz = 1'b0;
   logic          reset_n;
   logic          valid;
   logic          ov_valid;
   logic [31:0]   addr;
   logic [3:0]    wstrb;
   logic [8:0]    slave_ready;
   logic [287:0]  slave_rdata;

   logic          ready, write, err;
   logic [31:0]   rdata;
   logic [8:0]    sel;
   logic [7:0]    err_count;

   logic          ov_ready, ov_write, ov_err;
   logic [31:0]   ov_rdata;
   logic [1:0]    ov_sel;
   logic [7:0]    ov_err_count;

   int n_vec  = 0;
   int n_miss = 0;

   always #20 clk_25mhz = ~clk_25mhz;

   mem_bus_decoder #(
      .SLAVES         (9),
      .SLAVE_BASE     (STEPPER_BASE),
      .SLAVE_MASK     (STEPPER_MASK),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_in          (clk_25mhz),
      .reset_n_in      (reset_n),
      .mem_valid_in    (valid),
      .mem_addr_in     (addr),
      .mem_wstrb_in    (wstrb),
      .r_mem_ready_out (ready),
      .r_mem_rdata_out (rdata),
      .r_sel_out       (sel),
      .r_write_out     (write),
      .slave_ready_in  (slave_ready),
      .slave_rdata_in  (slave_rdata),
      .r_err_out       (err),
      .r_err_count_out (err_count)
   );

   // Region 0 matches everything, region 1 is RAM: both hit 0x1000.
   mem_bus_decoder #(
      .SLAVES     (2),
      .SLAVE_BASE ({32'h0000_1000, 32'h0000_0000}),
      .SLAVE_MASK ({32'hFFFF_F000, 32'h0000_0000})
   ) dut_ov (
      .clk_in          (clk_25mhz),
      .reset_n_in      (reset_n),
      .mem_valid_in    (ov_valid),
      .mem_addr_in     (addr),
      .mem_wstrb_in    (wstrb),
      .r_mem_ready_out (ov_ready),
      .r_mem_rdata_out (ov_rdata),
      .r_sel_out       (ov_sel),
      .r_write_out     (ov_write),
      .slave_ready_in  (2'b00),
      .slave_rdata_in  (64'h0),
      .r_err_out       (ov_err),
      .r_err_count_out (ov_err_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_25mhz);
   endtask

   initial begin
      reset_n     = 1'b0;
      valid       = 1'b0;
      ov_valid    = 1'b0;
      addr        = '0;
      wstrb       = '0;
      slave_ready = '0;
      slave_rdata = '0;

      #5;
      chk("rst_sel",   sel, 0);
      chk("rst_ready", ready, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err",   err, 0);
      chk("rst_cnt",   err_count, 0);
      chk("rst_write", write, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // read IO slot 2, ready one cycle after select
      valid = 1'b1; addr = 32'h1000_0000;
      tick();
      chk("rd_sel",      sel, 9'b000000100);
      chk("rd_rdy_wait", ready, 0);
      slave_ready = 9'b000000100;
      slave_rdata[2*32 +: 32] = 32'h0000_000F;
      tick();
      chk("rd_ready", ready, 1);
      chk("rd_rdata", rdata, 32'h0000_000F);
      chk("rd_err",   err, 0);
      chk("rd_sel_clr", sel, 0);
      valid = 1'b0; slave_ready = '0;
      tick();
      chk("rd_ready_pulse", ready, 0);
      chk("rd_rdata_hold",  rdata, 32'h0000_000F);

      // unmapped access
      valid = 1'b1; addr = 32'h2000_0000;
      tick();
      chk("um_ready", ready, 1);
      chk("um_rdata", rdata, 32'hDEAD_BEEF);
      chk("um_err",   err, 1);
      chk("um_cnt",   err_count, 1);
      chk("um_sel",   sel, 0);
      valid = 1'b0;
      tick();
      chk("um_ready_pulse", ready, 0);
      chk("um_err_pulse",   err, 0);

      // timeout: slave 3 never ready
      valid = 1'b1; addr = 32'h1000_0004;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("to_sel",   sel, 9'b000001000);
         chk("to_ready", ready, 0);
         tick();
      end
      chk("to_ready_end", ready, 1);
      chk("to_err",       err, 1);
      chk("to_rdata",     rdata, 32'hDEAD_BEEF);
      chk("to_sel_clr",   sel, 0);
      chk("to_cnt",       err_count, 2);
      valid = 1'b0;
      tick();

      // ready on the 4th WAIT cycle wins over timeout
      valid = 1'b1; addr = 32'h1000_0008;
      slave_rdata[4*32 +: 32] = 32'h1234_5678;
      tick();
      tick();
      tick();
      tick();
      chk("late_sel",   sel, 9'b000010000);
      slave_ready = 9'b000010000;
      tick();
      chk("late_ready", ready, 1);
      chk("late_rdata", rdata, 32'h1234_5678);
      chk("late_err",   err, 0);
      chk("late_cnt",   err_count, 2);
      valid = 1'b0; slave_ready = '0;
      tick();

      // write to RAM
      valid = 1'b1; addr = 32'h0000_1010; wstrb = 4'b0011;
      tick();
      chk("wr_sel",   sel, 9'b000000010);
      chk("wr_write", write, 1);
      slave_ready = 9'b000000010;
      tick();
      chk("wr_ready", ready, 1);
      valid = 1'b0; wstrb = '0; slave_ready = '0;
      tick();

      // overlapping regions, then valid dropped mid-WAIT
      ov_valid = 1'b1; addr = 32'h0000_1000;
      tick();
      chk("ov_sel", ov_sel, 2'b01);
      ov_valid = 1'b0;
      tick();
      chk("ab_sel",   ov_sel, 0);
      chk("ab_ready", ov_ready, 0);
      chk("ab_err",   ov_err, 0);
      tick();
      chk("ab_ready_late", ov_ready, 0);

      // 300 unmapped accesses saturate the error count
      for (int i = 0; i < 300; i++) begin
         valid = 1'b1; addr = 32'h2000_0000;
         tick();
         if (i == 299) chk("sat_err", err, 1);
         valid = 1'b0;
         tick();
      end
      chk("sat_cnt", err_count, 255);

      // reset asserted mid-WAIT
      valid = 1'b1; addr = 32'h1000_0000;
      tick();
      chk("mr_sel", sel, 9'b000000100);
      tick();
      #5 reset_n = 1'b0;
      #1;
      chk("mr_sel0",   sel, 0);
      chk("mr_ready0", ready, 0);
      chk("mr_rdata0", rdata, 0);
      chk("mr_err0",   err, 0);
      chk("mr_cnt0",   err_count, 0);
      chk("mr_write0", write, 0);
      valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("mr_no_ready", ready, 0);

      // next request after reset, ROM slot 0
      valid = 1'b1; addr = 32'h0000_0100;
      slave_rdata[0 +: 32] = 32'hCAFE_F00D;
      tick();
      chk("pr_sel", sel, 9'b000000001);
      slave_ready = 9'b000000001;
      tick();
      chk("pr_ready", ready, 1);
      chk("pr_rdata", rdata, 32'hCAFE_F00D);
      chk("pr_err",   err, 0);
      valid = 1'b0; slave_ready = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
